herald_result_serializer: RTL and testbench



---
 rtl/herald_pkg.sv | 19 +
 rtl/herald_result_serializer.sv | 140 ++++++++++++++
 tb/tb_herald_result_serializer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/herald_pkg.sv
// Shared types and constants for the herald result serializer.
package herald_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_SYNC,
        SEND_TAG,
        SEND_PAY,
        SEND_CSUM
    } ser_state_e;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Number of bytes needed to carry a word of the given bit width.
    function automatic int unsigned nbytes(input int unsigned width);
        return (width + 32'd7) / 32'd8;
    endfunction

endpackage

// File: rtl/herald_result_serializer.sv
// Pulls one result word through a RDY/EN handshake and emits it as a framed byte
// stream: SYNC, TAG, payload bytes LSB first, XOR checksum of tag and payload.
module herald_result_serializer
    import herald_pkg::*;
#(
    parameter int unsigned RESULT_W  = 104,
    parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [7:0]          tag_in,
    input  logic [RESULT_W-1:0] res_data,
    input  logic                res_rdy,
    output logic                res_en,
    output logic [7:0]          byte_out,
    output logic                byte_valid,
    input  logic                byte_ready,
    output logic                busy,
    output logic                frame_done
);

    localparam int unsigned NBYTES = nbytes(RESULT_W);
    localparam int unsigned PAY_W  = NBYTES * 8;
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    ser_state_e        state_q, state_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        tag_q, tag_d;
    logic [PAY_W-1:0]  payload_q, payload_d;
    logic [7:0]        byte_out_q, byte_out_d;
    logic              byte_valid_q, byte_valid_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              accept;

    // Consume strobe is combinational so the producer sees it in the capture cycle.
    assign res_en = (state_q == IDLE) & enable & res_rdy & ~rst;
    assign accept = byte_valid_q & byte_ready;

    // Next-state, capture and checksum update.
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        csum_d       = csum_q;
        tag_d        = tag_q;
        payload_d    = payload_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (res_en) begin
                    payload_d = PAY_W'(res_data);
                    tag_d     = tag_in;
                    csum_d    = tag_in;
                    index_d   = '0;
                    state_d   = SEND_SYNC;
                end
            end
            SEND_SYNC: begin
                if (accept) begin
                    state_d = SEND_TAG;
                end
            end
            SEND_TAG: begin
                if (accept) begin
                    index_d = '0;
                    state_d = SEND_PAY;
                end
            end
            SEND_PAY: begin
                if (accept) begin
                    csum_d = csum_q ^ byte_out_q;
                    if (index_q == LAST_IDX) begin
                        index_d = '0;
                        state_d = SEND_CSUM;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                    end
                end
            end
            SEND_CSUM: begin
                if (accept) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output byte is derived from the next state so it is registered and holds under backpressure.
    always_comb begin
        byte_out_d   = 8'h00;
        byte_valid_d = (state_d != IDLE);
        busy_d       = (state_d != IDLE);

        case (state_d)
            SEND_SYNC: byte_out_d = SYNC_BYTE;
            SEND_TAG:  byte_out_d = tag_d;
            SEND_PAY:  byte_out_d = payload_d[{index_d, 3'b000} +: 8];
            SEND_CSUM: byte_out_d = csum_d;
            default:   byte_out_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            index_q      <= '0;
            csum_q       <= 8'h00;
            tag_q        <= 8'h00;
            payload_q    <= '0;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            csum_q       <= csum_d;
            tag_q        <= tag_d;
            payload_q    <= payload_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_herald_result_serializer.sv
// Directed bench for herald_result_serializer: 104-bit and 36-bit instances.
module tb_herald_result_serializer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: default 104-bit result
    logic         enable_a, res_rdy_a, res_en_a, byte_valid_a, byte_ready_a, busy_a, frame_done_a;
    logic [7:0]   tag_a, byte_out_a;
    logic [103:0] data_a;

    // Instance B: 36-bit result, exercises padding of the last payload byte
    logic         enable_b, res_rdy_b, res_en_b, byte_valid_b, byte_ready_b, busy_b, frame_done_b;
    logic [7:0]   tag_b, byte_out_b;
    logic [35:0]  data_b;

    herald_result_serializer u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable_a),
        .tag_in     (tag_a),
        .res_data   (data_a),
        .res_rdy    (res_rdy_a),
        .res_en     (res_en_a),
        .byte_out   (byte_out_a),
        .byte_valid (byte_valid_a),
        .byte_ready (byte_ready_a),
        .busy       (busy_a),
        .frame_done (frame_done_a)
    );

    herald_result_serializer #(.RESULT_W(36)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable_b),
        .tag_in     (tag_b),
        .res_data   (data_b),
        .res_rdy    (res_rdy_b),
        .res_en     (res_en_b),
        .byte_out   (byte_out_b),
        .byte_valid (byte_valid_b),
        .byte_ready (byte_ready_b),
        .busy       (busy_b),
        .frame_done (frame_done_b)
    );

    localparam logic [103:0] BASIC = 104'h0102030405060708090A0B0C0D;
    logic [7:0] exp_basic [16] = '{8'hA5, 8'h3C, 8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h09, 8'h08,
                                   8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h3D};
    logic [7:0] exp_b [8] = '{8'hA5, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h0F,
                              8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12 ^ 8'h0F};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Negedge monitors: inputs change just after posedge, so values are settled here.
    int         cyc = 0;
    logic [7:0] qa[$];
    int         qa_cyc[$];
    int         en_cyc[$];
    int         en_cnt = 0, en_busy = 0, fd_cnt = 0, fd_cyc = 0, n09 = 0;
    logic [7:0] qb[$];
    int         en_b = 0, fd_b = 0;

    always @(negedge clk) begin
        cyc++;
        if (res_en_a) begin
            en_cnt++;
            en_cyc.push_back(cyc);
            if (busy_a) en_busy++;
        end
        if (byte_valid_a && byte_ready_a) begin
            qa.push_back(byte_out_a);
            qa_cyc.push_back(cyc);
        end
        if (byte_valid_a && byte_out_a == 8'h09) n09++;
        if (frame_done_a) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (res_en_b) en_b++;
        if (byte_valid_b && byte_ready_b) qb.push_back(byte_out_b);
        if (frame_done_b) fd_b++;
    end

    // One full frame on instance A, optionally stalling while payload byte 09 is shown.
    task automatic run_frame_a(input string name, input int stall);
        int q0 = qa.size();
        int e0 = en_cnt;
        int f0 = fd_cnt;
        int n0 = n09;
        int st = stall;
        @(posedge clk); #1;
        tag_a = 8'h3C; data_a = BASIC; res_rdy_a = 1'b1; enable_a = 1'b1; byte_ready_a = 1'b1;
        #1 chk({name, "_en_now"}, 32'(res_en_a), 32'd1);
        for (int i = 0; i < 80 && fd_cnt == f0; i++) begin
            @(posedge clk); #1;
            if (en_cnt > e0) res_rdy_a = 1'b0;
            if (st > 0 && byte_valid_a && byte_out_a == 8'h09) begin
                byte_ready_a = 1'b0;
                st--;
            end else begin
                byte_ready_a = 1'b1;
            end
        end
        enable_a = 1'b0;
        byte_ready_a = 1'b1;
        chk({name, "_done"}, 32'(fd_cnt - f0), 32'd1);
        chk({name, "_en_cnt"}, 32'(en_cnt - e0), 32'd1);
        chk({name, "_len"}, 32'(qa.size() - q0), 32'd16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s_b%0d", name, i),
                (q0 + i < qa.size()) ? 32'(qa[q0 + i]) : 32'hDEAD, 32'(exp_basic[i]));
        chk({name, "_hold09"}, 32'(n09 - n0), 32'(stall + 1));
        if (en_cnt > e0 && qa.size() - q0 >= 16) begin
            chk({name, "_lat_sync"}, 32'(qa_cyc[q0] - en_cyc[e0]), 32'd1);
            chk({name, "_lat_csum"}, 32'(qa_cyc[q0 + 15] - en_cyc[e0]), 32'(16 + stall));
            chk({name, "_done_lag"}, 32'(fd_cyc - qa_cyc[q0 + 15]), 32'd1);
        end
    endtask

    initial begin
        int q0, e0, f0, eb0, b0, busy0;
        rst = 1'b1;
        enable_a = 1'b1; res_rdy_a = 1'b1; tag_a = 8'h00; data_a = '0; byte_ready_a = 1'b1;
        enable_b = 1'b0; res_rdy_b = 1'b0; tag_b = 8'h00; data_b = '0; byte_ready_b = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_en", 32'(res_en_a), 32'd0);
        chk("rst_valid", 32'(byte_valid_a), 32'd0);
        chk("rst_byte", 32'(byte_out_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(frame_done_a), 32'd0);
        enable_a = 1'b0; res_rdy_a = 1'b0;
        rst = 1'b0;

        run_frame_a("basic", 0);
        run_frame_a("bp", 3);

        // Continuous producer: one capture per 17 cycles, enable dropped in the third frame
        e0 = en_cnt; f0 = fd_cnt; q0 = qa.size(); busy0 = en_busy;
        @(posedge clk); #1;
        tag_a = 8'h3C; data_a = BASIC; res_rdy_a = 1'b1; enable_a = 1'b1; byte_ready_a = 1'b1;
        repeat (40) @(posedge clk);
        #1 enable_a = 1'b0;
        repeat (30) @(posedge clk);
        #1 res_rdy_a = 1'b0;
        chk("cont_en_cnt", 32'(en_cnt - e0), 32'd3);
        if (en_cnt - e0 >= 3) begin
            chk("cont_gap1", 32'(en_cyc[e0 + 1] - en_cyc[e0]), 32'd17);
            chk("cont_gap2", 32'(en_cyc[e0 + 2] - en_cyc[e0 + 1]), 32'd17);
        end
        chk("cont_en_busy", 32'(en_busy - busy0), 32'd0);
        chk("cont_frames", 32'(fd_cnt - f0), 32'd3);
        chk("cont_bytes", 32'(qa.size() - q0), 32'd48);

        // Reset after five payload bytes abandons the frame
        e0 = en_cnt; f0 = fd_cnt; q0 = qa.size();
        @(posedge clk); #1;
        tag_a = 8'h3C; data_a = BASIC; res_rdy_a = 1'b1; enable_a = 1'b1;
        for (int i = 0; i < 40 && (qa.size() - q0) < 7; i++) begin
            @(posedge clk); #1;
            if (en_cnt > e0) begin
                res_rdy_a = 1'b0;
                enable_a = 1'b0;
            end
        end
        chk("mid_bytes", 32'(qa.size() - q0), 32'd7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_valid", 32'(byte_valid_a), 32'd0);
        chk("mid_busy", 32'(busy_a), 32'd0);
        repeat (25) @(posedge clk);
        #1;
        chk("mid_no_done", 32'(fd_cnt - f0), 32'd0);
        chk("mid_en_cnt", 32'(en_cnt - e0), 32'd1);
        run_frame_a("restart", 0);

        // Producer ready but enable low: nothing happens until enable rises
        @(posedge clk); #1;
        res_rdy_a = 1'b1; enable_a = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk($sformatf("dis_en_%0d", i), 32'(res_en_a), 32'd0);
            chk($sformatf("dis_valid_%0d", i), 32'(byte_valid_a), 32'd0);
        end
        run_frame_a("enrise", 0);

        // 36-bit instance: zero-padded top payload byte
        b0 = qb.size(); f0 = fd_b; eb0 = en_b;
        @(posedge clk); #1;
        tag_b = 8'h00; data_b = 36'hF12345678; res_rdy_b = 1'b1; enable_b = 1'b1;
        for (int i = 0; i < 40 && fd_b == f0; i++) begin
            @(posedge clk); #1;
            if (en_b > eb0) res_rdy_b = 1'b0;
        end
        enable_b = 1'b0;
        chk("w36_done", 32'(fd_b - f0), 32'd1);
        chk("w36_len", 32'(qb.size() - b0), 32'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("w36_b%0d", i),
                (b0 + i < qb.size()) ? 32'(qb[b0 + i]) : 32'hDEAD, 32'(exp_b[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
